// File: rtl/psg_array_ctrl.sv
// psg_array_ctrl: bus arbitration, read-back mux and stereo mixer
// for an array of externally instantiated PSG chips.
module psg_array_ctrl #(
    parameter int NUM_CHIPS = 4,
    parameter int AW        = 8,
    parameter int OW        = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    disable_all,
    input  logic [NUM_CHIPS-1:0]    chip_en,
    input  logic                    bdir,
    input  logic                    bc1,
    input  logic [7:0]              din,
    output logic [NUM_CHIPS-1:0]    chip_sel,
    input  logic [8*NUM_CHIPS-1:0]  chip_dout,
    input  logic [NUM_CHIPS-1:0]    chip_oe_n,
    output logic [7:0]              dout,
    output logic                    oe_n,
    input  logic [AW*NUM_CHIPS-1:0] chip_audio,
    input  logic [2*NUM_CHIPS-1:0]  pan,
    input  logic                    sample_stb,
    output logic [OW-1:0]           audio_l,
    output logic [OW-1:0]           audio_r,
    output logic                    mix_valid,
    output logic                    overrun
);

    localparam int IW   = $clog2(NUM_CHIPS);
    localparam int ACCW = AW + IW;
    localparam logic [3:0]    NC   = 4'(NUM_CHIPS);
    localparam logic [IW-1:0] LAST = IW'(NUM_CHIPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    logic [7:0]    cd [NUM_CHIPS];
    logic [AW-1:0] ca [NUM_CHIPS];
    logic [1:0]    pn [NUM_CHIPS];

    for (genvar i = 0; i < NUM_CHIPS; i++) begin : g_unpack
        assign cd[i] = chip_dout[8*i +: 8];
        assign ca[i] = chip_audio[AW*i +: AW];
        assign pn[i] = pan[2*i +: 2];
    end

    logic [IW-1:0] sel_idx;
    logic [2:0]    k;
    logic [7:0]    en_ext;
    logic          sel_wr;

    assign k = ~din[2:0];

    // Widen the enable mask so any 3-bit latch index is a legal lookup.
    always_comb begin
        en_ext = '0;
        en_ext[NUM_CHIPS-1:0] = chip_en;
    end

    assign sel_wr = bdir && bc1 && (din[7:3] == 5'b11111) &&
                    ({1'b0, k} < NC) && en_ext[k] && !disable_all;

    // Active chip index, moved only by a qualifying latch write.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_idx <= '0;
        end else if (sel_wr) begin
            sel_idx <= k[IW-1:0];
        end
    end

    // One-hot decode of the selected chip onto the A8 lines.
    always_comb begin
        chip_sel = '0;
        chip_sel[sel_idx] = 1'b1;
    end

    assign dout = cd[sel_idx];
    assign oe_n = (chip_en[sel_idx] && !disable_all) ?
                  chip_oe_n[sel_idx] : 1'b1;

    state_t        state;
    logic [IW-1:0] idx;
    logic [ACCW-1:0] acc_l, acc_r;
    logic [ACCW-1:0] sum_l, sum_r;
    logic [AW-1:0]   smp;
    logic [OW-1:0]   sat_l, sat_r;

    assign smp   = (chip_en[idx] && !disable_all) ? ca[idx] : '0;
    assign sum_l = acc_l + (pn[idx][0] ? ACCW'(smp) : '0);
    assign sum_r = acc_r + (pn[idx][1] ? ACCW'(smp) : '0);

    if (OW >= ACCW) begin : g_wide
        assign sat_l = OW'(sum_l);
        assign sat_r = OW'(sum_r);
    end else begin : g_sat
        assign sat_l = (|sum_l[ACCW-1:OW]) ? '1 : sum_l[OW-1:0];
        assign sat_r = (|sum_r[ACCW-1:OW]) ? '1 : sum_r[OW-1:0];
    end

    assign overrun = sample_stb && (state != IDLE) && !reset;

    // Mixer FSM: one chip per ACC cycle, final sum registered on exit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            acc_l     <= '0;
            acc_r     <= '0;
            audio_l   <= '0;
            audio_r   <= '0;
            mix_valid <= 1'b0;
        end else begin
            mix_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (sample_stb) begin
                        acc_l <= '0;
                        acc_r <= '0;
                        idx   <= '0;
                        state <= ACC;
                    end
                end
                ACC: begin
                    acc_l <= sum_l;
                    acc_r <= sum_r;
                    idx   <= idx + 1'b1;
                    if (idx == LAST) begin
                        audio_l   <= sat_l;
                        audio_r   <= sat_r;
                        mix_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psg_array_ctrl.sv
// tb_psg_array_ctrl: scoreboard bench for psg_array_ctrl,
// default OW=10 instance alongside a saturating OW=9 instance.
module tb_psg_array_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        disable_all;
    logic [3:0]  chip_en;
    logic        bdir, bc1;
    logic [7:0]  din;
    logic [31:0] chip_dout;
    logic [3:0]  chip_oe_n;
    logic [31:0] chip_audio;
    logic [7:0]  pan;
    logic        sample_stb;

    logic [3:0]  chip_sel, chip_sel9;
    logic [7:0]  dout, dout9;
    logic        oe_n, oe_n9;
    logic [9:0]  audio_l, audio_r;
    logic [8:0]  audio_l9, audio_r9;
    logic        mix_valid, mix_valid9;
    logic        overrun, overrun9;

    typedef struct {
        int l;
        int r;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    psg_array_ctrl #(.NUM_CHIPS(4), .AW(8), .OW(10)) dut (
        .clk(clk), .reset(reset), .disable_all(disable_all),
        .chip_en(chip_en), .bdir(bdir), .bc1(bc1), .din(din),
        .chip_sel(chip_sel), .chip_dout(chip_dout),
        .chip_oe_n(chip_oe_n), .dout(dout), .oe_n(oe_n),
        .chip_audio(chip_audio), .pan(pan),
        .sample_stb(sample_stb), .audio_l(audio_l),
        .audio_r(audio_r), .mix_valid(mix_valid),
        .overrun(overrun)
    );

    psg_array_ctrl #(.NUM_CHIPS(4), .AW(8), .OW(9)) dut9 (
        .clk(clk), .reset(reset), .disable_all(disable_all),
        .chip_en(chip_en), .bdir(bdir), .bc1(bc1), .din(din),
        .chip_sel(chip_sel9), .chip_dout(chip_dout),
        .chip_oe_n(chip_oe_n), .dout(dout9), .oe_n(oe_n9),
        .chip_audio(chip_audio), .pan(pan),
        .sample_stb(sample_stb), .audio_l(audio_l9),
        .audio_r(audio_r9), .mix_valid(mix_valid9),
        .overrun(overrun9)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int sat9(input int v);
        return (v > 511) ? 511 : v;
    endfunction

    // Output side of the scoreboard: pop on every mix_valid.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (mix_valid || mix_valid9) begin
            chk("mv_pair", mix_valid9, mix_valid);
            if (q.size() == 0) begin
                chk("spurious_mix_valid", 1, 0);
            end else begin
                e = q.pop_front();
                chk("mix_latency", cyc, e.cyc);
                chk("audio_l", audio_l, e.l);
                chk("audio_r", audio_r, e.r);
                chk("audio_l9", audio_l9, sat9(e.l));
                chk("audio_r9", audio_r9, sat9(e.r));
            end
        end
    end

    task automatic latch(input logic [7:0] v, input int pre, input int post);
        @(negedge clk);
        bdir = 1'b1; bc1 = 1'b1; din = v;
        #1 chk("sel_pre", chip_sel, pre);
        @(negedge clk);
        bdir = 1'b0; bc1 = 1'b0; din = 8'h00;
        #1 chk("sel_post", chip_sel, post);
        chk("sel_post9", chip_sel9, post);
    endtask

    // Input side: model the mix from held inputs, push, then strobe.
    task automatic do_mix(input int gap);
        exp_t e;
        int   l = 0, r = 0, s;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            s = (chip_en[i] && !disable_all) ? int'(chip_audio[i*8 +: 8]) : 0;
            if (pan[2*i])   l += s;
            if (pan[2*i+1]) r += s;
        end
        e.l = l; e.r = r; e.cyc = cyc + 5;
        q.push_back(e);
        sample_stb = 1'b1;
        #1 chk("ovr_idle", overrun, 0);
        @(negedge clk);
        sample_stb = 1'b0;
        if (gap > 0) begin
            repeat (gap - 1) @(negedge clk);
            sample_stb = 1'b1;
            #1 chk("ovr_busy", overrun, 1);
            chk("ovr_busy9", overrun9, 1);
            @(negedge clk);
            sample_stb = 1'b0;
            #1 chk("ovr_pulse", overrun, 0);
        end
        for (int n = 0; n < 20 && q.size() != 0; n++) @(negedge clk);
        if (q.size() != 0) begin
            chk("mix_timeout", q.size(), 0);
            q.delete();
        end
        @(negedge clk);
        chk("hold_l", audio_l, l);
        chk("hold_r", audio_r, r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; disable_all = 1'b0; chip_en = 4'b1111;
        bdir = 1'b0; bc1 = 1'b0; din = 8'h00;
        chip_dout = '0; chip_oe_n = 4'b1111;
        chip_audio = '0; pan = '0; sample_stb = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_sel", chip_sel, 1);
        chk("rst_audio_l", audio_l, 0);
        chk("rst_audio_r", audio_r, 0);
        chk("rst_mix_valid", mix_valid, 0);
        chk("rst_overrun", overrun, 0);
        reset = 1'b0;

        latch(8'hFE, 1, 2);
        latch(8'hF8, 2, 2);
        latch(8'hFD, 2, 4);
        disable_all = 1'b1;
        latch(8'hFF, 4, 4);
        disable_all = 1'b0;
        latch(8'hFF, 4, 1);
        latch(8'h7E, 1, 1);

        chip_en = 4'b1101;
        latch(8'hFE, 1, 1);
        chip_oe_n = 4'b1110;
        chip_dout = 32'h3C_96_5A_A5;
        #1;
        chk("dout", dout, 8'hA5);
        chk("dout9", dout9, 8'hA5);
        chk("oe_n_on", oe_n, 0);
        chip_en = 4'b1100;
        #1 chk("oe_n_chip_off", oe_n, 1);
        chk("oe_n9_chip_off", oe_n9, 1);
        chip_en = 4'b1111;
        disable_all = 1'b1;
        #1 chk("oe_n_dis_all", oe_n, 1);
        disable_all = 1'b0;
        latch(8'hFC, 1, 8);
        #1 chk("dout_chip3", dout, 8'h3C);

        chip_audio = {8'd40, 8'd30, 8'd20, 8'd10};
        pan = {2'b00, 2'b10, 2'b01, 2'b11};
        do_mix(0);

        chip_en = 4'b1011;
        do_mix(0);
        chip_en = 4'b1111;

        disable_all = 1'b1;
        do_mix(0);
        disable_all = 1'b0;

        chip_audio = 32'hFFFF_FFFF;
        pan = 8'hFF;
        do_mix(0);

        for (int j = 0; j < 4; j++) begin
            chip_audio = $urandom;
            pan = 8'($urandom);
            chip_en = 4'($urandom) | 4'b0001;
            do_mix(0);
        end
        chip_en = 4'b1111;

        chip_audio = {8'd4, 8'd3, 8'd2, 8'd1};
        pan = 8'b11_10_01_11;
        do_mix(2);

        latch(8'hFE, 8, 2);
        @(negedge clk);
        sample_stb = 1'b1;
        @(negedge clk);
        sample_stb = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("abort_sel", chip_sel, 1);
        chk("abort_audio_l", audio_l, 0);
        chk("abort_audio_r", audio_r, 0);
        chk("abort_mix_valid", mix_valid, 0);
        reset = 1'b0;
        repeat (8) @(negedge clk);

        chip_audio = {8'd40, 8'd30, 8'd20, 8'd10};
        pan = {2'b00, 2'b10, 2'b01, 2'b11};
        do_mix(0);

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/psg_array_ctrl.md
Name: psg_array_ctrl

Overview:
- Parametrised successor of the two-chip TurboSound selector: arbitrates CPU bus access across NUM_CHIPS PSG instances, which are instantiated externally.
- Selects the active chip through in-band register-latch writes, muxes read-back data and applies per-chip enable masking.
- A time-multiplexed mixer with per-chip stereo panning produces saturated left/right samples.
- Sits between the ULA/bus decode and the PSG instances; its outputs feed the audio DAC path.

Parameters:
- NUM_CHIPS, 4, number of PSG chips (2..8).
- AW, 8, per-chip audio sample width (unsigned).
- OW, 10, mixed output width per stereo side (unsigned).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- disable_all  in  1  disables every chip: no selection change, oe_n forced 1, zero audio
- chip_en  in  NUM_CHIPS  per-chip enable mask, bit i = chip i
- bdir  in  1  PSG bus direction
- bc1  in  1  PSG bus control 1
- din  in  8  CPU data bus
- chip_sel  out  NUM_CHIPS  one-hot select to each chip's A8 input
- chip_dout  in  8*NUM_CHIPS  packed chip read data, chip i at [8i+7:8i]
- chip_oe_n  in  NUM_CHIPS  per-chip output-enable, active low
- dout  out  8  read data of the selected chip
- oe_n  out  1  active-low read enable toward the CPU
- chip_audio  in  AW*NUM_CHIPS  packed per-chip audio
- pan  in  2*NUM_CHIPS  per-chip pan: 00 mute, 01 left, 10 right, 11 both
- sample_stb  in  1  one-cycle mix request
- audio_l  out  OW  mixed left sample
- audio_r  out  OW  mixed right sample
- mix_valid  out  1  one-cycle pulse when audio_l/audio_r update
- overrun  out  1  one-cycle pulse when sample_stb arrives while the mixer is busy

Behaviour:
- Reset values: sel_idx=0, so chip_sel=1 (one-hot, bit 0); audio_l=audio_r=0; mix_valid=0; overrun=0; FSM=IDLE; accumulators=0.
- Selection write:
  - Condition: bdir&&bc1 && din[7:3]==5'b11111 && k<NUM_CHIPS, where k=~din[2:0] (FF selects chip 0, FE chip 1, ... F8 chip 7).
  - The write also requires chip_en[k]==1 and disable_all==0.
  - Effect: sel_idx<=k, taking effect the next cycle.
  - A qualifying latch value with k>=NUM_CHIPS, or with chip k disabled, leaves sel_idx unchanged.
  - The latch still reaches the chips as a normal address; no blocking is applied.
- chip_sel is combinational one-hot decode of sel_idx.
- dout = chip_dout[sel_idx], combinational.
- oe_n = chip_oe_n[sel_idx] when chip_en[sel_idx] && !disable_all, else 1.
- Changing chip_en does not move sel_idx. If the selected chip is disabled, oe_n reads 1 until a new selection is made.
- Mixer FSM, states IDLE, ACC, DONE:
  - IDLE: on sample_stb, clear acc_l/acc_r, set idx=0, go to ACC.
  - ACC: one chip per cycle. Sample s = (chip_en[idx] && !disable_all) ? chip_audio[idx] : 0. Add s to acc_l if pan[2idx]=1 and to acc_r if pan[2idx+1]=1. idx increments; after idx==NUM_CHIPS-1 go to DONE.
  - DONE: register audio_l/audio_r, pulse mix_valid, return to IDLE.
- Latency: sample_stb in cycle t gives ACC in cycles t+1..t+NUM_CHIPS and mix_valid high in cycle t+NUM_CHIPS+1, with new outputs visible in that same cycle. Minimum strobe spacing is NUM_CHIPS+2 cycles.
- Inputs are sampled in the ACC cycle that processes each chip; the mixer does not snapshot them.
- Accumulator width is AW+clog2(NUM_CHIPS).
  - If OW is at least that width: zero-extend.
  - Otherwise saturate: any sum > 2^OW-1 outputs 2^OW-1.
- sample_stb in ACC or DONE is ignored and pulses overrun in the same cycle; the mix in progress is unaffected.
- sample_stb together with a selection write: both are handled independently.
- reset asserted mid-mix: abort, return to reset values next cycle, no mix_valid.
- audio_l/audio_r hold their value between mix_valid pulses.

Test Plan:
- After reset, write latch FE (chip_en=1111): chip_sel goes 0001→0010 one cycle later. Then write F8: no change (k=7≥4). Then FD: chip_sel=0100.
- chip_en=1101, write FE: selection ignored and chip_sel stays 0001. Set chip_oe_n[0]=0 and chip_dout[0]=A5: dout=A5, oe_n=0. Clear chip_en[0]: oe_n=1.
- Audio=10,20,30,40 with pan=11,01,10,00, pulse sample_stb: mix_valid 5 cycles later with audio_l=30 (10+20) and audio_r=40 (10+30).
- OW=9, all audio=FF, pan=11, chip_en=1111: audio_l=audio_r=511 (saturated). With default OW=10: 1020.
- sample_stb, then again 2 cycles later: overrun pulses once; a single mix_valid with the first mix's result.
- Assert reset during ACC: no mix_valid; outputs 0 and chip_sel=0001 the following cycle. A new strobe then mixes normally.
